ofs_plat_avalon_mem_rdwr_responder: RTL and testbench
=====================================================

OFS_PLAT_AVALON_MEM_RDWR_RESPONDER -- requirements
Module: ofs_plat_avalon_mem_rdwr_responder

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, word address width; DATA_WIDTH, default 64, data width in bits; BURST_CNT_WIDTH, default 4, burstcount width.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  the block's single clock; all logic SHALL be on posedge clk
  reset  input  1  synchronous, active-high reset
  rd_waitrequest  output  1  read command stall
  rd_read  input  1  read command valid
  rd_address  input  ADDR_WIDTH  read word address
  rd_burstcount  input  BURST_CNT_WIDTH  read beats
  rd_byteenable  input  DATA_WIDTH/8  ignored
  rd_readdatavalid  output  1  read beat valid
  rd_readdata  output  DATA_WIDTH  read beat data
  rd_response  output  2  read beat status
  wr_waitrequest  output  1  write beat stall
  wr_write  input  1  write beat valid
  wr_address  input  ADDR_WIDTH  write word address, sampled on first beat only
  wr_burstcount  input  BURST_CNT_WIDTH  write beats, sampled on first beat only
  wr_writedata  input  DATA_WIDTH  write beat data
  wr_byteenable  input  DATA_WIDTH/8  per-byte write enable
  wr_writeresponsevalid  output  1  one pulse per completed write burst
  wr_response  output  2  write burst status

Function
REQ-003 The block SHALL respond on the slave end of a split read/write Avalon memory bus and SHALL back a memory of 2^ADDR_WIDTH words of DATA_WIDTH bits.
REQ-004 Read FSM SHALL have two states. In RD_IDLE it SHALL hold rd_waitrequest=0. In RD_BURST it SHALL hold rd_waitrequest=1.
REQ-005 A read SHALL be accepted when rd_read=1 and rd_waitrequest=0. On acceptance the FSM SHALL capture address and burstcount and move to RD_BURST.
REQ-006 The first rd_readdatavalid SHALL assert exactly 1 cycle after the acceptance cycle. Beats SHALL be back-to-back, one per cycle, returning mem[(addr+i) mod 2^ADDR_WIDTH].
REQ-007 The FSM SHALL return to RD_IDLE in the cycle its last beat is issued. The next read SHALL be acceptable in the cycle after the last rd_readdatavalid.
REQ-008 rd_burstcount=0 SHALL produce a single beat with rd_readdata=0 and rd_response=SLVERR (2'b10). All other beats SHALL carry OKAY (2'b00).
REQ-009 Write FSM SHALL have two states, WR_IDLE and WR_BURST. wr_waitrequest SHALL be 0 outside reset.
REQ-010 Each accepted write beat SHALL write wr_writedata into word (base+beat index) mod 2^ADDR_WIDTH, under wr_byteenable.
REQ-011 A write burst with burstcount N SHALL consume N beats. wr_writeresponsevalid SHALL pulse once, 1 cycle after the last beat, with wr_response=OKAY.
REQ-012 A write burst with wr_burstcount=0 SHALL consume one beat, write nothing, and respond SLVERR.
REQ-013 Same-cycle read of a word being written SHALL return the old data (read-before-write).
REQ-014 Read and write channels SHALL be independent; concurrent bursts SHALL NOT stall each other.
REQ-015 Beat counters SHALL be BURST_CNT_WIDTH bits wide, and a burstcount of 2^BURST_CNT_WIDTH-1 SHALL complete without overflow.

Reset
REQ-016 While reset=1 the outputs SHALL be: rd_waitrequest=1, wr_waitrequest=1, rd_readdatavalid=0, wr_writeresponsevalid=0, rd_readdata=0, rd_response=0, wr_response=0.
REQ-017 While reset=1 both FSMs SHALL be in IDLE with counters at 0.
REQ-018 Reset mid-burst SHALL abort the burst: no further beats and no write response SHALL be issued. Memory contents SHALL NOT be reset.

Structure
REQ-019 Package ofs_plat_avalon_mem_responder_pkg SHALL hold the response code constants (OKAY, SLVERR) and the rd/wr FSM state typedefs.
REQ-020 The storage SHALL be sub-module ofs_plat_avalon_mem_responder_ram: simple dual-port, 1-cycle registered read, byte-enabled write, read-before-write.

Verification
REQ-021 The bench SHALL cover these scenarios:
  Write addr 0x10, burst 4, data 1..4, be all-ones -> one wr_writeresponsevalid 1 cycle after beat 4, OKAY.
  Then read addr 0x10, burst 4 -> data 1,2,3,4 on consecutive cycles starting 1 cycle after accept; rd_waitrequest=1 for 4 cycles.
  Write addr 0x3FE, burst 4 (ADDR_WIDTH=10) -> words 0x3FE, 0x3FF, 0x000, 0x001 written; read back matches.
  rd_burstcount=0 -> one beat, data 0, SLVERR. wr_burstcount=0 -> memory unchanged, SLVERR.
  Byteenable 0x0F over 0xFFFF..FF on word holding 0 -> reads back 0x00000000FFFFFFFF.
  Assert reset during beat 2 of a read burst of 8 -> no rd_readdatavalid after reset. After reset, read of 1 beat at the same address returns data.

Source files
------------

// File: rtl/ofs_plat_avalon_mem_responder_pkg.sv
// rtl/ofs_plat_avalon_mem_responder_pkg.sv - response codes and FSM state types for the rd/wr responder
package ofs_plat_avalon_mem_responder_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_t;

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_responder_if.sv
// rtl/ofs_plat_avalon_mem_rdwr_responder_if.sv - split read/write Avalon memory bus with master/slave modports
interface ofs_plat_avalon_mem_rdwr_responder_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4
);
    logic                       rd_waitrequest;
    logic                       rd_read;
    logic [ADDR_WIDTH-1:0]      rd_address;
    logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
    logic [DATA_WIDTH/8-1:0]    rd_byteenable;
    logic                       rd_readdatavalid;
    logic [DATA_WIDTH-1:0]      rd_readdata;
    logic [1:0]                 rd_response;

    logic                       wr_waitrequest;
    logic                       wr_write;
    logic [ADDR_WIDTH-1:0]      wr_address;
    logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
    logic [DATA_WIDTH-1:0]      wr_writedata;
    logic [DATA_WIDTH/8-1:0]    wr_byteenable;
    logic                       wr_writeresponsevalid;
    logic [1:0]                 wr_response;

    modport slave (
        output rd_waitrequest, rd_readdatavalid, rd_readdata, rd_response,
        input  rd_read, rd_address, rd_burstcount, rd_byteenable,
        output wr_waitrequest, wr_writeresponsevalid, wr_response,
        input  wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable
    );

    modport master (
        input  rd_waitrequest, rd_readdatavalid, rd_readdata, rd_response,
        output rd_read, rd_address, rd_burstcount, rd_byteenable,
        input  wr_waitrequest, wr_writeresponsevalid, wr_response,
        output wr_write, wr_address, wr_burstcount, wr_writedata, wr_byteenable
    );

endinterface

// File: rtl/ofs_plat_avalon_mem_responder_ram.sv
// rtl/ofs_plat_avalon_mem_responder_ram.sv - simple dual-port RAM, byte-enabled write, registered read-before-write
module ofs_plat_avalon_mem_responder_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Both ports update on the same edge, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_responder.sv
// rtl/ofs_plat_avalon_mem_rdwr_responder.sv - memory-backed slave for a split read/write Avalon bus
module ofs_plat_avalon_mem_rdwr_responder
    import ofs_plat_avalon_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    ofs_plat_avalon_mem_rdwr_responder_if.slave bus
);
    rd_state_t                  r_rd_state;
    logic                       r_rd_wait;
    logic                       r_rd_valid;
    logic                       r_rd_zero;
    logic [1:0]                 r_rd_resp;
    logic [ADDR_WIDTH-1:0]      r_rd_addr;
    logic [BURST_CNT_WIDTH-1:0] r_rd_left;

    wr_state_t                  r_wr_state;
    logic                       r_wr_wait;
    logic                       r_wr_rv;
    logic [1:0]                 r_wr_resp;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    logic [BURST_CNT_WIDTH-1:0] r_wr_left;

    logic                       w_rd_accept;
    logic                       w_rd_bc_zero;
    logic [ADDR_WIDTH-1:0]      w_ram_raddr;
    logic [DATA_WIDTH-1:0]      w_ram_rdata;
    logic                       w_wr_beat;
    logic                       w_wr_bc_zero;
    logic                       w_ram_we;
    logic [ADDR_WIDTH-1:0]      w_ram_waddr;

    assign w_rd_accept  = bus.rd_read && !r_rd_wait && (r_rd_state == RD_IDLE);
    assign w_rd_bc_zero = (bus.rd_burstcount == '0);
    // In idle the RAM is addressed straight from the bus so the first beat lands one cycle after accept.
    assign w_ram_raddr  = (r_rd_state == RD_IDLE) ? bus.rd_address : r_rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_rd_wait  <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_rd_resp  <= OKAY;
            r_rd_addr  <= '0;
            r_rd_left  <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_rd_wait  <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_rd_zero  <= 1'b0;
                    r_rd_resp  <= OKAY;
                    if (w_rd_accept) begin
                        r_rd_state <= RD_BURST;
                        r_rd_wait  <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_zero  <= w_rd_bc_zero;
                        r_rd_resp  <= w_rd_bc_zero ? SLVERR : OKAY;
                        r_rd_addr  <= bus.rd_address + ADDR_WIDTH'(1);
                        r_rd_left  <= w_rd_bc_zero ? '0
                                                   : bus.rd_burstcount - BURST_CNT_WIDTH'(1);
                    end
                end
                RD_BURST: begin
                    if (r_rd_left != '0) begin
                        r_rd_valid <= 1'b1;
                        r_rd_zero  <= 1'b0;
                        r_rd_resp  <= OKAY;
                        r_rd_addr  <= r_rd_addr + ADDR_WIDTH'(1);
                        r_rd_left  <= r_rd_left - BURST_CNT_WIDTH'(1);
                    end else begin
                        r_rd_state <= RD_IDLE;
                        r_rd_wait  <= 1'b0;
                        r_rd_valid <= 1'b0;
                        r_rd_zero  <= 1'b0;
                        r_rd_resp  <= OKAY;
                    end
                end
            endcase
        end
    end

    assign w_wr_beat    = bus.wr_write && !r_wr_wait;
    assign w_wr_bc_zero = (bus.wr_burstcount == '0);
    // A zero-length burst still consumes its beat but must leave memory untouched.
    assign w_ram_we     = w_wr_beat && !reset && !((r_wr_state == WR_IDLE) && w_wr_bc_zero);
    assign w_ram_waddr  = (r_wr_state == WR_IDLE) ? bus.wr_address : r_wr_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
            r_wr_wait  <= 1'b1;
            r_wr_rv    <= 1'b0;
            r_wr_resp  <= OKAY;
            r_wr_addr  <= '0;
            r_wr_left  <= '0;
        end else begin
            r_wr_wait <= 1'b0;
            r_wr_rv   <= 1'b0;
            r_wr_resp <= OKAY;
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_wr_beat) begin
                        if (w_wr_bc_zero) begin
                            r_wr_rv   <= 1'b1;
                            r_wr_resp <= SLVERR;
                        end else if (bus.wr_burstcount == BURST_CNT_WIDTH'(1)) begin
                            r_wr_rv   <= 1'b1;
                        end else begin
                            r_wr_state <= WR_BURST;
                            r_wr_addr  <= bus.wr_address + ADDR_WIDTH'(1);
                            r_wr_left  <= bus.wr_burstcount - BURST_CNT_WIDTH'(1);
                        end
                    end
                end
                WR_BURST: begin
                    if (w_wr_beat) begin
                        r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                        r_wr_left <= r_wr_left - BURST_CNT_WIDTH'(1);
                        if (r_wr_left == BURST_CNT_WIDTH'(1)) begin
                            r_wr_rv    <= 1'b1;
                            r_wr_state <= WR_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    ofs_plat_avalon_mem_responder_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (bus.wr_writedata),
        .i_be    (bus.wr_byteenable),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    assign bus.rd_waitrequest        = r_rd_wait;
    assign bus.rd_readdatavalid      = r_rd_valid;
    assign bus.rd_readdata           = (r_rd_valid && !r_rd_zero) ? w_ram_rdata : '0;
    assign bus.rd_response           = r_rd_resp;
    assign bus.wr_waitrequest        = r_wr_wait;
    assign bus.wr_writeresponsevalid = r_wr_rv;
    assign bus.wr_response           = r_wr_resp;

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv
// tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv - directed self-checking bench for the rd/wr responder
module tb_ofs_plat_avalon_mem_rdwr_responder;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    ofs_plat_avalon_mem_rdwr_responder_if #(
        .ADDR_WIDTH(10), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)
    ) bus ();

    ofs_plat_avalon_mem_rdwr_responder #(
        .ADDR_WIDTH(10), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    int          rd_n, rd_first, rd_last, rd_wait_cnt, rd_idle_at;
    int          wr_pulses, wr_first;
    logic [1:0]  wr_resp_seen;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_drive(input logic [9:0] addr, input logic [3:0] bc);
        rd_n = 0; rd_first = -1; rd_last = -1; rd_wait_cnt = 0; rd_idle_at = -1;
        bus.rd_read = 1'b1;
        bus.rd_address = addr;
        bus.rd_burstcount = bc;
        bus.rd_byteenable = '1;
        tick;
        bus.rd_read = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (bus.rd_readdatavalid) begin
                if (rd_n < 16) begin
                    rd_data[rd_n] = bus.rd_readdata;
                    rd_resp[rd_n] = bus.rd_response;
                end
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                rd_n++;
            end
            if (bus.rd_waitrequest) rd_wait_cnt++;
            else if (rd_idle_at < 0 && rd_n > 0) rd_idle_at = k;
            tick;
        end
    endtask

    task automatic wr_drive(input logic [9:0] addr, input logic [3:0] bc, input int beats,
                            input logic [63:0] d0, input logic [7:0] be);
        wr_pulses = 0; wr_first = 99; wr_resp_seen = 2'bxx;
        for (int i = 0; i < beats; i++) begin
            bus.wr_write = 1'b1;
            bus.wr_address = addr;
            bus.wr_burstcount = bc;
            bus.wr_writedata = d0 + 64'(i);
            bus.wr_byteenable = be;
            tick;
            if (i < beats - 1 && bus.wr_writeresponsevalid) begin
                wr_pulses++;
                wr_first = -1;
            end
        end
        bus.wr_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.wr_writeresponsevalid) begin
                wr_pulses++;
                if (wr_first == 99) wr_first = k;
                wr_resp_seen = bus.wr_response;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        tests++; if (bus.rd_waitrequest !== 1'b1) begin fails++; $display("FAIL reset_rd_wait: got %b expected 1", bus.rd_waitrequest); end
        tests++; if (bus.wr_waitrequest !== 1'b1) begin fails++; $display("FAIL reset_wr_wait: got %b expected 1", bus.wr_waitrequest); end
        tests++; if (bus.rd_readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_readdatavalid); end
        tests++; if (bus.wr_writeresponsevalid !== 1'b0) begin fails++; $display("FAIL reset_wr_rv: got %b expected 0", bus.wr_writeresponsevalid); end
        tests++; if (bus.rd_readdata !== 64'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_readdata); end
        tests++; if (bus.rd_response !== 2'b00) begin fails++; $display("FAIL reset_rd_resp: got %b expected 00", bus.rd_response); end
        tests++; if (bus.wr_response !== 2'b00) begin fails++; $display("FAIL reset_wr_resp: got %b expected 00", bus.wr_response); end
        reset = 1'b0;
        tick;
        tests++; if (bus.rd_waitrequest !== 1'b0) begin fails++; $display("FAIL post_reset_rd_wait: got %b expected 0", bus.rd_waitrequest); end
        tests++; if (bus.wr_waitrequest !== 1'b0) begin fails++; $display("FAIL post_reset_wr_wait: got %b expected 0", bus.wr_waitrequest); end
    endtask

    task automatic test_write_burst;
        wr_drive(10'h010, 4'd4, 4, 64'd1, 8'hFF);
        tests++; if (wr_pulses !== 1) begin fails++; $display("FAIL wr4_pulses: got %0d expected 1", wr_pulses); end
        tests++; if (wr_first !== 0) begin fails++; $display("FAIL wr4_latency: got %0d expected 0", wr_first); end
        tests++; if (wr_resp_seen !== 2'b00) begin fails++; $display("FAIL wr4_resp: got %b expected 00", wr_resp_seen); end
    endtask

    task automatic test_read_burst;
        rd_drive(10'h010, 4'd4);
        tests++; if (rd_n !== 4) begin fails++; $display("FAIL rd4_beats: got %0d expected 4", rd_n); end
        tests++; if (rd_first !== 1) begin fails++; $display("FAIL rd4_latency: got %0d expected 1", rd_first); end
        tests++; if (rd_last !== 4) begin fails++; $display("FAIL rd4_contiguous: got %0d expected 4", rd_last); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== 64'(i + 1) || rd_resp[i] !== 2'b00) begin fails++; $display("FAIL rd4_beat%0d: got %h/%b expected %h/00", i, rd_data[i], rd_resp[i], i + 1); end
        end
        tests++; if (rd_wait_cnt !== 4) begin fails++; $display("FAIL rd4_wait_cycles: got %0d expected 4", rd_wait_cnt); end
        tests++; if (rd_idle_at !== 5) begin fails++; $display("FAIL rd4_reaccept: got %0d expected 5", rd_idle_at); end
    endtask

    task automatic test_wrap;
        wr_drive(10'h3FE, 4'd4, 4, 64'hA0, 8'hFF);
        tests++; if (wr_pulses !== 1 || wr_resp_seen !== 2'b00) begin fails++; $display("FAIL wrap_wr_resp: got %0d/%b expected 1/00", wr_pulses, wr_resp_seen); end
        rd_drive(10'h3FE, 4'd4);
        for (int i = 0; i < 4; i++) begin
            tests++; if (rd_data[i] !== 64'hA0 + 64'(i)) begin fails++; $display("FAIL wrap_rd_beat%0d: got %h expected %h", i, rd_data[i], 64'hA0 + 64'(i)); end
        end
        rd_drive(10'h000, 4'd1);
        tests++; if (rd_n !== 1 || rd_data[0] !== 64'hA2) begin fails++; $display("FAIL wrap_word0: got %0d/%h expected 1/a2", rd_n, rd_data[0]); end
        rd_drive(10'h001, 4'd1);
        tests++; if (rd_data[0] !== 64'hA3) begin fails++; $display("FAIL wrap_word1: got %h expected a3", rd_data[0]); end
    endtask

    task automatic test_zero_burst;
        rd_drive(10'h010, 4'd0);
        tests++; if (rd_n !== 1) begin fails++; $display("FAIL rd0_beats: got %0d expected 1", rd_n); end
        tests++; if (rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10) begin fails++; $display("FAIL rd0_beat: got %h/%b expected 0/10", rd_data[0], rd_resp[0]); end
        wr_drive(10'h010, 4'd0, 1, 64'hDEAD, 8'hFF);
        tests++; if (wr_pulses !== 1 || wr_first !== 0) begin fails++; $display("FAIL wr0_pulse: got %0d@%0d expected 1@0", wr_pulses, wr_first); end
        tests++; if (wr_resp_seen !== 2'b10) begin fails++; $display("FAIL wr0_resp: got %b expected 10", wr_resp_seen); end
        rd_drive(10'h010, 4'd1);
        tests++; if (rd_data[0] !== 64'h1) begin fails++; $display("FAIL wr0_mem_unchanged: got %h expected 1", rd_data[0]); end
    endtask

    task automatic test_byteenable;
        wr_drive(10'h020, 4'd1, 1, 64'h0, 8'hFF);
        wr_drive(10'h020, 4'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        rd_drive(10'h020, 4'd1);
        tests++; if (rd_data[0] !== 64'h0000_0000_FFFF_FFFF) begin fails++; $display("FAIL byteenable: got %h expected 00000000ffffffff", rd_data[0]); end
    endtask

    task automatic test_concurrent;
        fork
            rd_drive(10'h010, 4'd4);
            wr_drive(10'h080, 4'd3, 3, 64'h900, 8'hFF);
        join
        tests++; if (rd_n !== 4 || rd_first !== 1 || rd_last !== 4) begin fails++; $display("FAIL conc_rd_timing: got %0d beats %0d..%0d expected 4 beats 1..4", rd_n, rd_first, rd_last); end
        tests++; if (rd_data[3] !== 64'h4) begin fails++; $display("FAIL conc_rd_data: got %h expected 4", rd_data[3]); end
        tests++; if (wr_pulses !== 1 || wr_first !== 0 || wr_resp_seen !== 2'b00) begin fails++; $display("FAIL conc_wr_resp: got %0d@%0d/%b expected 1@0/00", wr_pulses, wr_first, wr_resp_seen); end
        rd_drive(10'h080, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tests++; if (rd_data[i] !== 64'h900 + 64'(i)) begin fails++; $display("FAIL conc_readback%0d: got %h expected %h", i, rd_data[i], 64'h900 + 64'(i)); end
        end
    endtask

    task automatic test_read_before_write;
        fork
            rd_drive(10'h010, 4'd1);
            wr_drive(10'h010, 4'd1, 1, 64'h55, 8'hFF);
        join
        tests++; if (rd_data[0] !== 64'h1) begin fails++; $display("FAIL rbw_old: got %h expected 1", rd_data[0]); end
        rd_drive(10'h010, 4'd1);
        tests++; if (rd_data[0] !== 64'h55) begin fails++; $display("FAIL rbw_new: got %h expected 55", rd_data[0]); end
    endtask

    task automatic test_max_burst;
        wr_drive(10'h100, 4'd15, 15, 64'h200, 8'hFF);
        tests++; if (wr_pulses !== 1 || wr_first !== 0) begin fails++; $display("FAIL max_wr_resp: got %0d@%0d expected 1@0", wr_pulses, wr_first); end
        rd_drive(10'h100, 4'd15);
        tests++; if (rd_n !== 15 || rd_wait_cnt !== 15) begin fails++; $display("FAIL max_rd_len: got %0d beats %0d wait expected 15/15", rd_n, rd_wait_cnt); end
        for (int i = 0; i < 15; i++) begin
            tests++; if (rd_data[i] !== 64'h200 + 64'(i)) begin fails++; $display("FAIL max_rd_beat%0d: got %h expected %h", i, rd_data[i], 64'h200 + 64'(i)); end
        end
    endtask

    task automatic test_reset_mid_read;
        int seen;
        wr_drive(10'h040, 4'd8, 8, 64'h100, 8'hFF);
        bus.rd_read = 1'b1;
        bus.rd_address = 10'h040;
        bus.rd_burstcount = 4'd8;
        tick;
        bus.rd_read = 1'b0;
        tick;
        tests++; if (bus.rd_readdatavalid !== 1'b1 || bus.rd_readdata !== 64'h101) begin fails++; $display("FAIL midrst_beat2: got %b/%h expected 1/101", bus.rd_readdatavalid, bus.rd_readdata); end
        reset = 1'b1;
        tick;
        tests++; if (bus.rd_readdatavalid !== 1'b0 || bus.rd_waitrequest !== 1'b1) begin fails++; $display("FAIL midrst_abort: got valid %b wait %b expected 0/1", bus.rd_readdatavalid, bus.rd_waitrequest); end
        tick;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.rd_readdatavalid || bus.wr_writeresponsevalid) seen++;
            tick;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_beats: got %0d expected 0", seen); end
        rd_drive(10'h040, 4'd1);
        tests++; if (rd_n !== 1 || rd_data[0] !== 64'h100) begin fails++; $display("FAIL midrst_readback: got %0d/%h expected 1/100", rd_n, rd_data[0]); end
    endtask

    initial begin
        bus.rd_read = 1'b0;
        bus.rd_address = '0;
        bus.rd_burstcount = '0;
        bus.rd_byteenable = '1;
        bus.wr_write = 1'b0;
        bus.wr_address = '0;
        bus.wr_burstcount = '0;
        bus.wr_writedata = '0;
        bus.wr_byteenable = '0;
        test_reset;
        test_write_burst;
        test_read_burst;
        test_wrap;
        test_zero_burst;
        test_byteenable;
        test_concurrent;
        test_read_before_write;
        test_max_burst;
        test_reset_mid_read;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
